// File: rtl/seq_mult32_pkg.sv
// seq_mult32_pkg: shared constants and state encoding for the sequential multiplier
package seq_mult32_pkg;
  localparam int MULT_WIDTH = 32;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = 5'd31;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/seq_mult32_neg32_cond.sv
// neg32_cond: conditional two's-complement negate of a WIDTH-bit value
module neg32_cond #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);
  assign y = neg ? -x : x;
endmodule

// File: rtl/seq_mult32.sv
// seq_mult32: 32-cycle shift-add multiplier, signed via sign-magnitude conversion
module seq_mult32
  import seq_mult32_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic             Sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Lo,
  output logic [WIDTH-1:0] Hi
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand, mplier, a_mag, b_mag;
  logic [2*WIDTH-1:0] acc, acc_nx, prod;
  logic [WIDTH:0] sum;
  logic neg;
  neg32_cond #(.WIDTH(WIDTH)) u_neg_a (.neg(Sign & A[WIDTH-1]), .x(A), .y(a_mag));
  neg32_cond #(.WIDTH(WIDTH)) u_neg_b (.neg(Sign & B[WIDTH-1]), .x(B), .y(b_mag));
  neg32_cond #(.WIDTH(2*WIDTH)) u_neg_p (.neg(neg), .x(acc_nx), .y(prod));
  // 33-bit sum keeps the carry so it shifts into the top of the accumulator
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{mplier[0]}}};
  assign acc_nx = {sum, acc[WIDTH-1:1]};
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (Start ? RUN : IDLE) :
               state == RUN  ? (cnt == CNT_LAST ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      Lo     <= '0;
      Hi     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && Start) begin
        mcand  <= a_mag;
        mplier <= b_mag;
        neg    <= Sign & (A[WIDTH-1] ^ B[WIDTH-1]);
        acc    <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= acc_nx;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (cnt == CNT_LAST) {Hi, Lo} <= prod;
      end
    end
  end
endmodule

// File: tb/tb_seq_mult32.sv
// tb_seq_mult32: directed-vector self-checking bench for seq_mult32
module tb_seq_mult32;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sign = 1'b0;
  logic [31:0] a = '0, b = '0, lo, hi;
  logic busy, done;
  int tests = 0, fails = 0;

  seq_mult32 dut (
    .Clk(clk), .Rst(rst), .Start(start), .Sign(sign), .A(a), .B(b),
    .Busy(busy), .Done(done), .Lo(lo), .Hi(hi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drives Start across one rising edge (edge k); returns at the sample after edge k
  task automatic start_op(input logic s, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; sign = s; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
  endtask

  // poke >= 0 issues a stray Start (A=B=2) at that sample
  task automatic run_op(input string tag, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [63:0] exp, input int poke);
    int lat, busy_n, changes, extra;
    logic [63:0] held;
    held = {hi, lo};
    lat = 99; busy_n = 0; changes = 0; extra = 0;
    start_op(s, av, bv);
    for (int j = 0; j < 60; j++) begin
      if (busy) busy_n++;
      if (done) begin lat = j; break; end
      if ({hi, lo} !== held) changes++;
      if (j == poke) begin start = 1'b1; a = 32'd2; b = 32'd2; end
      else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'd32);
    chk({tag, " busy"}, 64'(busy_n), 64'd33);
    chk({tag, " hold"}, 64'(changes), 64'd0);
    chk({tag, " product"}, {hi, lo}, exp);
    @(negedge clk);
    chk({tag, " post"}, {62'd0, busy, done}, 64'd0);
    for (int j = 0; j < 40; j++) begin
      if (done) extra++;
      @(negedge clk);
    end
    chk({tag, " no second done"}, 64'(extra), 64'd0);
    chk({tag, " idle hold"}, {hi, lo}, exp);
  endtask

  initial begin
    int dn;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset", {hi, lo, 30'd0, busy, done}, 96'd0);
    run_op("u6x7", 1'b0, 32'd6, 32'd7, 64'd42, -1);
    run_op("umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
    run_op("sm3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, -1);
    run_op("smin2", 1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, -1);
    run_op("umfd5", 1'b0, 32'hFFFF_FFFD, 32'd5, 64'h0000_0004_FFFF_FFF1, -1);
    run_op("sminx3", 1'b1, 32'h8000_0000, 32'd3, 64'hFFFF_FFFE_8000_0000, -1);
    run_op("sm1m1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd1, -1);
    run_op("ignore", 1'b0, 32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780, 10);
    // abort: Rst high on edge k+15
    start_op(1'b0, 32'd100, 32'd200);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort state", {hi, lo, 30'd0, busy, done}, 96'd0);
    rst = 1'b0;
    dn = 0;
    for (int j = 0; j < 40; j++) begin
      if (done) dn++;
      @(negedge clk);
    end
    chk("abort no done", 64'(dn), 64'd0);
    run_op("after rst", 1'b0, 32'd100, 32'd200, 64'd20000, -1);
    run_op("zero", 1'b0, 32'd0, 32'h1234_5678, 64'd0, -1);
    run_op("after zero", 1'b0, 32'd3, 32'd5, 64'd15, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_mult32.md
SEQ_MULT32 -- requirements
Module: seq_mult32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width; only 32 is required to be supported.
REQ-002 The block SHALL have Clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have Rst  input  1  reset; synchronous and active-high.
REQ-004 The block SHALL have Start  input  1  request pulse; sampled only in IDLE.
REQ-005 The block SHALL have Sign  input  1  1 = signed two's-complement operands, 0 = unsigned; sampled with Start.
REQ-006 The block SHALL have A  input  32  multiplicand; sampled with Start.
REQ-007 The block SHALL have B  input  32  multiplier; sampled with Start.
REQ-008 The block SHALL have Busy  output  1  high in RUN and DONE.
REQ-009 The block SHALL have Done  output  1  one-cycle completion pulse.
REQ-010 The block SHALL have Lo  output  32  product bits [31:0]; drives the A1 leg of the 32-bit result-select mux downstream.
REQ-011 The block SHALL have Hi  output  32  product bits [63:32].

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
- IDLE->RUN on Start=1.
- RUN->DONE when iteration count reaches 31.
- DONE->IDLE unconditionally.
REQ-013 On the edge that accepts Start (edge k), the block SHALL latch the operand magnitudes, the result sign (Sign & (A[31]^B[31])), clear the 64-bit accumulator and set the 5-bit count to 0.
REQ-014 Each RUN edge SHALL perform one shift-add step: if the current multiplier LSB is 1, add the multiplicand into the upper accumulator half (33-bit sum, carry kept); then shift the accumulator/multiplier right by one and increment the count.
REQ-015 On edge k+32, the final iteration SHALL complete, the state SHALL enter DONE, and Lo/Hi SHALL be loaded with the 64-bit product, negated (two's complement across all 64 bits) when the result sign is 1.
REQ-016 Done SHALL be 1 for exactly the cycle after edge k+32 and 0 otherwise; fixed latency of 33 edges from Start acceptance to Done visible.
REQ-017 Lo/Hi SHALL hold their value from DONE until the next DONE entry; they SHALL NOT change during RUN.
REQ-018 Start asserted in RUN or DONE SHALL be ignored (no queueing); Start held high through DONE SHALL be accepted on the first IDLE cycle.
REQ-019 Operands SHALL be treated as unsigned when Sign=0.
REQ-020 When Sign=1, magnitude conversion SHALL handle A or B = 0x80000000 correctly (magnitude 2^31 in a 32-bit unsigned field).
REQ-021 A or B equal to 0 SHALL still take the full 33-edge latency and yield Hi=Lo=0 (no early exit).

Reset
REQ-022 When Rst=1 at a rising edge, the block SHALL force state IDLE, count 0, Busy=0, Done=0, Lo=0, Hi=0, accumulator 0; Rst has priority over Start.
REQ-023 Rst asserted mid-RUN or in DONE SHALL abort the operation with no Done pulse; Lo/Hi SHALL read 0 after that edge.

Structure
REQ-024 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the iteration count limit (31) and WIDTH SHALL live in a shared CPU constants package/include used by the control unit.
REQ-025 Sign-magnitude pre-/post-conversion SHALL be one sub-module, neg32_cond (conditional two's-complement negate, parameterised width), instantiated for A, B and the 64-bit result; the datapath and FSM stay in seq_mult32.

Verification
REQ-026 Unsigned basic: Sign=0, A=6, B=7, Start pulse -> Done exactly 33 edges later; Hi=0, Lo=42; Busy high for 33 cycles.
REQ-027 Unsigned max: A=B=0xFFFFFFFF, Sign=0 -> Hi=0xFFFFFFFE, Lo=0x00000001.
REQ-028 Signed: Sign=1, A=0xFFFFFFFD (-3), B=5 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFF1; A=B=0x80000000 -> Hi=0x40000000, Lo=0.
REQ-029 Ignored start: a second Start at edge k+10 with A=2, B=2 -> single Done at k+33 carrying the first product; no second Done.
REQ-030 Reset mid-operation: Rst=1 at edge k+15 -> Busy=0, Done never pulses, Lo=Hi=0; a new Start after reset gives the correct product with full latency.
REQ-031 Zero/hold: A=0, B=0x12345678 -> Done at k+33, Lo=Hi=0; Lo/Hi stay stable through following IDLE cycles and through the next RUN until its DONE.
